video_layer_pipeline: RTL and testbench

Parametrised successor to the fixed bar+sprite video top. It owns the scan counter and drives (x, y) to LAYERS external layer generators that share one pixel latency. It composites their returns with priority and key-colour transparency, then buffers pixels in a credit-controlled FIFO. The output is a {rgb, sof} ready/valid stream that feeds vga_sync_core directly, which removes the hand-tuned delay synchronizers.

---
 rtl/video_pkg.sv | 18 +
 rtl/stream_fifo.sv | 51 +++++
 rtl/video_layer_pipeline.sv | 152 +++++++++++++++
 tb/tb_video_layer_pipeline.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared defaults and pixel/coordinate types for the layered video pipeline.
package video_pkg;

    localparam int DEF_CD   = 12;
    localparam int DEF_HMAX = 640;
    localparam int DEF_VMAX = 480;
    localparam int DEF_KEY  = 0;

    typedef logic [DEF_CD-1:0] rgb_t;

    typedef struct packed {
        rgb_t rgb;
        logic sof;
    } pix_s;

    typedef logic [10:0] coord_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and occupancy count.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Head word is gated so the output reads zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/video_layer_pipeline.sv
// Scan counter, layer tag pipe, priority/key compositor and credit-gated
// output FIFO producing a {rgb, sof} stream.
module video_layer_pipeline
    import video_pkg::*;
#(
    parameter int CD         = DEF_CD,
    parameter int HMAX       = DEF_HMAX,
    parameter int VMAX       = DEF_VMAX,
    parameter int LAYERS     = 4,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int KEY_COLOR  = DEF_KEY
) (
    input  logic                 clk,
    input  logic                 reset_sys,
    input  logic [LAYERS-1:0]    layer_en,
    input  logic [CD-1:0]        bg_rgb,
    output logic [10:0]          x,
    output logic [10:0]          y,
    output logic                 coord_valid,
    input  logic [LAYERS*CD-1:0] layer_rgb,
    output logic [CD:0]          so_data,
    output logic                 so_valid,
    input  logic                 so_ready,
    output logic                 frame_start,
    output logic [15:0]          frame_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = LAYERS + 2;

    logic [CW-1:0]     credit;
    logic              issue;
    logic              pop;
    logic              at_origin;
    logic              x_last;
    logic              y_last;
    logic [LAYERS-1:0] en_q;
    logic [LAYERS-1:0] en_use;
    logic [TW-1:0]     tag_q [LAT];
    logic              tag_v;
    logic              tag_sof;
    logic [LAYERS-1:0] tag_en;
    logic [CD-1:0]     mix_rgb;
    logic              comp_v;
    logic              comp_sof;
    logic [CD-1:0]     comp_rgb;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt;

    // Reset gates issue so nothing leaves the counter while held.
    assign issue       = reset_sys && (credit < CW'(FIFO_DEPTH));
    assign pop         = so_valid && so_ready;
    assign at_origin   = (x == '0) && (y == '0);
    assign x_last      = x == 11'(HMAX - 1);
    assign y_last      = y == 11'(VMAX - 1);
    assign coord_valid = issue;
    assign frame_start = issue && at_origin;
    assign en_use      = frame_start ? layer_en : en_q;

    always_ff @(posedge clk or negedge reset_sys) begin
        if (!reset_sys) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            en_q      <= '0;
        end else if (issue) begin
            if (frame_start) en_q <= layer_en;
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y         <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    y <= y + 11'd1;
                end
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_sys) begin
        if (!reset_sys) begin
            credit <= '0;
        end else begin
            credit <= credit + CW'(issue) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_sys) begin
        if (!reset_sys) begin
            for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= {issue, frame_start, en_use};
            for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign {tag_v, tag_sof, tag_en} = tag_q[LAT-1];

    // Highest layer index wins; key colour is see-through.
    always_comb begin
        logic found;
        found   = 1'b0;
        mix_rgb = bg_rgb;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (!found && tag_en[i]
                && layer_rgb[i*CD +: CD] != CD'(KEY_COLOR)) begin
                mix_rgb = layer_rgb[i*CD +: CD];
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_sys) begin
        if (!reset_sys) begin
            comp_v   <= 1'b0;
            comp_sof <= 1'b0;
            comp_rgb <= '0;
        end else begin
            comp_v   <= tag_v;
            comp_sof <= tag_sof;
            comp_rgb <= mix_rgb;
        end
    end

    stream_fifo #(
        .WIDTH (CD + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_sys),
        .wr_en   (comp_v),
        .wr_data ({comp_rgb, comp_sof}),
        .rd_en   (pop),
        .rd_data (so_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign so_valid = !fifo_empty;

    wr_full_a: assert property (@(posedge clk) disable iff (!reset_sys)
        !(comp_v && fifo_full));

    credit_a: assert property (@(posedge clk) disable iff (!reset_sys)
        credit >= fifo_cnt);

endmodule

// File: tb/tb_video_layer_pipeline.sv
// Self-checking bench: composite vectors, stall, enable toggle, mid-frame
// reset and random back-pressure against an issue-time scoreboard.
module tb_video_layer_pipeline;
    import video_pkg::*;

    localparam int CD    = 12;
    localparam int HMAX  = 16;
    localparam int VMAX  = 8;
    localparam int NL    = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset_sys = 1'b0;
    logic [NL-1:0]     layer_en = '0;
    logic [CD-1:0]     bg_rgb = 12'h00F;
    logic [10:0]       x, y;
    logic              coord_valid;
    logic [NL*CD-1:0]  layer_rgb;
    logic [CD:0]       so_data;
    logic              so_valid;
    logic              so_ready = 1'b1;
    logic              frame_start;
    logic [15:0]       frame_cnt;

    video_layer_pipeline #(
        .CD(CD), .HMAX(HMAX), .VMAX(VMAX), .LAYERS(NL),
        .LAT(LAT), .FIFO_DEPTH(DEPTH), .KEY_COLOR(0)
    ) dut (
        .clk(clk), .reset_sys(reset_sys), .layer_en(layer_en),
        .bg_rgb(bg_rgb), .x(x), .y(y), .coord_valid(coord_valid),
        .layer_rgb(layer_rgb), .so_data(so_data), .so_valid(so_valid),
        .so_ready(so_ready), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Layer generator model: mode 1 = constant colour, 2 = xy pattern
    int        lay_mode [NL];
    rgb_t      lay_col  [NL];
    logic [10:0] dx [LAT];
    logic [10:0] dy [LAT];

    function automatic rgb_t lval(input int m, input rgb_t c, input int i,
                                  input logic [10:0] xx,
                                  input logic [10:0] yy);
        if (m == 1) return c;
        if (((int'(xx) + int'(yy) + i) % 3) == 0) return 12'h000;
        return {4'(i + 1), xx[3:0], yy[3:0]};
    endfunction

    always @(posedge clk) begin
        dx[0] <= x;
        dy[0] <= y;
        for (int k = 1; k < LAT; k++) begin
            dx[k] <= dx[k-1];
            dy[k] <= dy[k-1];
        end
    end

    for (genvar gi = 0; gi < NL; gi++) begin : g_lay
        assign layer_rgb[gi*CD +: CD] =
            lval(lay_mode[gi], lay_col[gi], gi, dx[LAT-1], dy[LAT-1]);
    end

    function automatic rgb_t exp_rgb(input logic [NL-1:0] en,
                                     input int xx, input int yy);
        rgb_t r, v;
        r = bg_rgb;
        for (int i = 0; i < NL; i++) begin
            v = lval(lay_mode[i], lay_col[i], i, 11'(xx), 11'(yy));
            if (en[i] && v != 12'h000) r = v;
        end
        return r;
    endfunction

    // Scoreboard
    pix_s        q [$];
    int          ex, ey, mfr, sof_pops;
    logic [NL-1:0] en_m;
    logic        prev_hold;
    logic [CD:0] prev_data;

    always @(negedge clk) begin
        pix_s p;
        if (!reset_sys) begin
            q.delete();
            ex = 0; ey = 0; mfr = 0; sof_pops = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("hold_stable", so_data, prev_data);
            chk("frame_cnt", frame_cnt, 16'(mfr));
            chk("frame_start", frame_start,
                coord_valid && ex == 0 && ey == 0);
            if (coord_valid) begin
                chk("scan_xy", {x, y}, {11'(ex), 11'(ey)});
                if (ex == 0 && ey == 0) en_m = layer_en;
                p.rgb = exp_rgb(en_m, ex, ey);
                p.sof = (ex == 0 && ey == 0);
                q.push_back(p);
                if (ex == HMAX - 1) begin
                    ex = 0;
                    if (ey == VMAX - 1) begin
                        ey = 0;
                        mfr++;
                    end else ey++;
                end else ex++;
            end
            chk("credit_bound", q.size() <= DEPTH, 1);
            if (so_valid && so_ready) begin
                if (q.size() == 0) chk("pop_unexpected", so_data, 0);
                else begin
                    p = q.pop_front();
                    chk("pixel", so_data, p);
                end
                if (so_data[0]) sof_pops++;
            end
            prev_hold = so_valid && !so_ready;
            prev_data = so_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_sys = 1'b0;
        tick();
        tick();
        reset_sys = 1'b1;
    endtask

    task automatic wait_xy(input int wx, input int wy);
        bit hit;
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (coord_valid && x == 11'(wx) && y == 11'(wy)) begin
                hit = 1;
                break;
            end
        end
        chk("wait_xy", hit, 1);
        tick();
    endtask

    typedef struct packed {
        logic [NL-1:0] en;
        rgb_t bg;
        rgb_t c3, c2, c1, c0;
        rgb_t exp;
    } vec_t;

    vec_t vec [8];

    initial begin
        int lat, bad;
        bit found;

        vec[0] = '{4'b0000, 12'h00F, 12'hABC, 12'h111, 12'h222, 12'h333, 12'h00F};
        vec[1] = '{4'b1010, 12'h00F, 12'h000, 12'h555, 12'hF00, 12'h333, 12'hF00};
        vec[2] = '{4'b1010, 12'h00F, 12'h0F0, 12'h555, 12'hF00, 12'h333, 12'h0F0};
        vec[3] = '{4'b0101, 12'h00F, 12'hABC, 12'h000, 12'h222, 12'h123, 12'h123};
        vec[4] = '{4'b1111, 12'h456, 12'h000, 12'h000, 12'h000, 12'h000, 12'h456};
        vec[5] = '{4'b0111, 12'h00F, 12'hABC, 12'h000, 12'h000, 12'h789, 12'h789};
        vec[6] = '{4'b1000, 12'h00F, 12'hABC, 12'h111, 12'h111, 12'h111, 12'hABC};
        vec[7] = '{4'b0110, 12'h00F, 12'hABC, 12'hDEF, 12'h222, 12'h333, 12'hDEF};

        for (int i = 0; i < NL; i++) begin
            lay_mode[i] = 1;
            lay_col[i]  = 12'h000;
        end

        for (int v = 0; v < 8; v++) begin
            reset_sys = 1'b0;
            so_ready  = 1'b1;
            layer_en  = vec[v].en;
            bg_rgb    = vec[v].bg;
            lay_col[3] = vec[v].c3;
            lay_col[2] = vec[v].c2;
            lay_col[1] = vec[v].c1;
            lay_col[0] = vec[v].c0;
            tick();
            tick();
            chk("reset_state",
                {x, y, coord_valid, so_valid, so_data, frame_start, frame_cnt},
                64'd0);
            reset_sys = 1'b1;
            lat = -1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (k == 0) chk("first_issue", {coord_valid, frame_start}, 2'b11);
                if (so_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("latency", lat, LAT + 2);
            chk("vec_pixel", so_data, {vec[v].exp, 1'b1});
            tick();
            if (v == 0) begin
                repeat (130) tick();
                chk("frame1_cnt", frame_cnt, 1);
            end else begin
                repeat (4) tick();
            end
        end

        // Stall: credit caps issue, output holds, then drains in order
        for (int i = 0; i < NL; i++) lay_mode[i] = 2;
        layer_en = 4'b1111;
        bg_rgb   = 12'h00F;
        do_reset();
        repeat (20) tick();
        so_ready = 1'b0;
        repeat (50) tick();
        @(negedge clk);
        chk("stall_no_issue", coord_valid, 0);
        chk("stall_valid", so_valid, 1);
        begin
            logic [21:0] xy_s;
            xy_s = {x, y};
            repeat (3) tick();
            chk("stall_xy_hold", {x, y}, xy_s);
        end
        so_ready = 1'b1;
        repeat (200) tick();

        // Enable change mid-frame takes effect at next sof
        for (int i = 0; i < NL; i++) begin
            lay_mode[i] = 1;
            lay_col[i]  = 12'h000;
        end
        lay_col[3] = 12'hABC;
        lay_col[0] = 12'h789;
        layer_en   = 4'b1000;
        do_reset();
        wait_xy(5, 3);
        layer_en = 4'b0001;
        bad = 0;
        found = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (so_valid && so_ready) begin
                if (so_data[0]) begin
                    chk("toggle_sof_pix", so_data, {12'h789, 1'b1});
                    found = 1;
                    break;
                end else if (so_data[CD:1] != 12'hABC) bad++;
            end
        end
        chk("toggle_found", found, 1);
        chk("toggle_old_frame", bad, 0);

        // Mid-frame reset with data queued
        for (int i = 0; i < NL; i++) lay_mode[i] = 2;
        layer_en = 4'b1011;
        do_reset();
        wait_xy(8, 4);
        so_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("pre_reset_valid", so_valid, 1);
        tick();
        reset_sys = 1'b0;
        #1;
        chk("reset_outputs",
            {x, y, coord_valid, so_valid, so_data, frame_start, frame_cnt},
            64'd0);
        tick();
        reset_sys = 1'b1;
        so_ready  = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (so_valid) begin
                found = 1;
                break;
            end
        end
        chk("post_reset_out", found, 1);
        chk("post_reset_sof", so_data[0], 1);
        chk("post_reset_fcnt", frame_cnt, 0);

        // Random back-pressure over three frames
        layer_en = 4'b1101;
        bg_rgb   = 12'h0A5;
        do_reset();
        for (int k = 0; k < 5000; k++) begin
            so_ready = 1'($urandom_range(0, 1));
            tick();
            if (mfr >= 3) break;
        end
        chk("rand_frames", frame_cnt, 3);
        so_ready = 1'b1;
        repeat (30) tick();
        chk("rand_sof_pops", sof_pops, 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
